hero_write_rx: RTL and testbench

HERO_WRITE_RX -- requirements
Module: hero_write_rx

---
 rtl/hero_rx_pkg.sv | 19 +
 rtl/test_pkg_a.sv | 25 ++
 rtl/hero_rx_commit_fifo.sv | 90 +++++++++
 rtl/hero_write_rx.sv | 150 +++++++++++++++
 tb/tb_hero_write_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hero_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : hero_rx_pkg                                              |
// | Purpose   : Receiver FSM state encoding and default buffer sizing.   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package hero_rx_pkg;

   localparam int unsigned HERO_RX_DEPTH     = 16;
   localparam int unsigned HERO_RX_MAX_BEATS = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TXN  = 2'd1,
      S_DROP = 2'd2
   } hero_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/test_pkg_a.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : test_pkg_a                                               |
// | Purpose   : Shared HERO write-bus types: the cycle-type encoding and |
// |             the 41-bit hero_write beat {cycle_type, wdat, clk_en}.   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package test_pkg_a;

   // Only IDLE, VALID and DONE are legal. Every other 4-bit code is a
   // protocol error at the receiver.
   typedef enum logic [3:0] {
      IDLE  = 4'h0,
      VALID = 4'h1,
      DONE  = 4'h2
   } CYCLE_TYPE;

   typedef struct packed {
      CYCLE_TYPE   cycle_type;
      logic [35:0] wdat;
      logic        clk_en;
   } hero_write;

endpackage
`default_nettype wire

// File: rtl/hero_rx_commit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : hero_rx_commit_fifo                                      |
// | Purpose   : Beat buffer with speculative write pointer. Beats become |
// |             readable only once their transaction is committed; a     |
// |             rewind throws away the uncommitted tail.                 |
// | Ports     : clk, rst         - clock, synchronous active-high reset  |
// |             wr_en/wr_data/wr_last - write one beat                   |
// |             wr_commit        - this write closes the transaction     |
// |             rewind           - drop all uncommitted beats            |
// |             rd_valid/rd_data/rd_last/rd_ready - output handshake     |
// |             fill             - wr_ptr - rd_ptr (pre-read occupancy)  |
// |             txn_beats        - wr_ptr - cmt_ptr (open txn length)    |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module hero_rx_commit_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [35:0]              wr_data,
   input  logic                     wr_last,
   input  logic                     wr_commit,
   input  logic                     rewind,
   output logic                     rd_valid,
   output logic [35:0]              rd_data,
   output logic                     rd_last,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [$clog2(DEPTH):0]   txn_beats
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra MSB so full (difference == DEPTH) and
   // empty (difference == 0) are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] cmt_ptr_q, cmt_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [36:0] mem_q [DEPTH];
   logic [36:0] w_rd_entry;

   assign rd_valid   = (rd_ptr_q != cmt_ptr_q);
   assign w_rd_entry = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_data    = w_rd_entry[35:0];
   assign rd_last    = w_rd_entry[36];
   assign fill       = wr_ptr_q - rd_ptr_q;
   assign txn_beats  = wr_ptr_q - cmt_ptr_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      cmt_ptr_d = cmt_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (rd_valid && rd_ready) begin
         rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      if (rewind) begin
         wr_ptr_d = cmt_ptr_q;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + c_ptr_one;
         // Committing on the closing beat publishes it in the same edge.
         if (wr_commit) begin
            cmt_ptr_d = wr_ptr_q + c_ptr_one;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         cmt_ptr_q <= '0;
         rd_ptr_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         cmt_ptr_q <= cmt_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset: nothing is readable until committed.
   always_ff @(posedge clk) begin
      if (wr_en && !rewind) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
      end
   end

endmodule
`default_nettype wire

// File: rtl/hero_write_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : hero_write_rx                                            |
// | Purpose   : Receives HERO write beats, buffers each transaction and  |
// |             releases it to the consumer only when complete (DONE).   |
// |             Overlong or overflowing transactions are dropped whole.  |
// | Ports     : clk, rst         - clock, synchronous active-high reset  |
// |             hero_in          - {cycle_type, wdat, clk_en}            |
// |             out_valid/out_ready/out_data/out_last - beat output      |
// |             txn_count        - committed transactions (wrapping)     |
// |             err_overflow/err_too_long/err_bad_type - sticky errors   |
// |             err_clr          - clears the sticky errors              |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module hero_write_rx
   import test_pkg_a::*;
   import hero_rx_pkg::*;
#(
   parameter int unsigned DEPTH     = HERO_RX_DEPTH,
   parameter int unsigned MAX_BEATS = HERO_RX_MAX_BEATS
) (
   input  logic        clk,
   input  logic        rst,
   input  hero_write   hero_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [35:0] out_data,
   output logic        out_last,
   output logic [15:0] txn_count,
   output logic        err_overflow,
   output logic        err_too_long,
   output logic        err_bad_type,
   input  logic        err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_max_beats = (AW+1)'(MAX_BEATS);

   hero_rx_state_t state_q, state_d;
   logic [15:0]    txn_count_q, txn_count_d;
   logic           err_overflow_q, err_overflow_d;
   logic           err_too_long_q, err_too_long_d;
   logic           err_bad_type_q, err_bad_type_d;

   logic           w_is_valid, w_is_done, w_is_bad;
   logic           w_wr_en, w_wr_last, w_commit, w_rewind;
   logic           w_set_ovf, w_set_long;
   logic [AW:0]    w_fill, w_txn_beats;

   assign w_is_valid = hero_in.clk_en && (hero_in.cycle_type == VALID);
   assign w_is_done  = hero_in.clk_en && (hero_in.cycle_type == DONE);
   assign w_is_bad   = hero_in.clk_en && (hero_in.cycle_type != IDLE)
                       && (hero_in.cycle_type != VALID)
                       && (hero_in.cycle_type != DONE);

   hero_rx_commit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (w_wr_en),
      .wr_data   (hero_in.wdat),
      .wr_last   (w_wr_last),
      .wr_commit (w_commit),
      .rewind    (w_rewind),
      .rd_valid  (out_valid),
      .rd_data   (out_data),
      .rd_last   (out_last),
      .rd_ready  (out_ready),
      .fill      (w_fill),
      .txn_beats (w_txn_beats)
   );

   always_comb begin
      state_d     = state_q;
      w_wr_en     = 1'b0;
      w_wr_last   = 1'b0;
      w_commit    = 1'b0;
      w_rewind    = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_long  = 1'b0;

      if (w_is_valid || w_is_done) begin
         case (state_q)
            S_IDLE, S_TXN: begin
               // Fullness uses the pre-read occupancy; a same-cycle read
               // does not make room for this beat.
               if (w_fill == c_depth) begin
                  w_set_ovf = 1'b1;
                  w_rewind  = 1'b1;
               end else if (w_txn_beats == c_max_beats) begin
                  w_set_long = 1'b1;
                  w_rewind   = 1'b1;
               end else begin
                  w_wr_en   = 1'b1;
                  w_wr_last = w_is_done;
                  w_commit  = w_is_done;
               end
               // A rejected DONE already ends the transaction, so there is
               // nothing left to drop.
               if (w_rewind) begin
                  state_d = w_is_done ? S_IDLE : S_DROP;
               end else begin
                  state_d = w_is_done ? S_IDLE : S_TXN;
               end
            end
            S_DROP: begin
               if (w_is_done) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A newly detected error takes priority over a simultaneous clear.
      err_overflow_d = (err_overflow_q && !err_clr) || w_set_ovf;
      err_too_long_d = (err_too_long_q && !err_clr) || w_set_long;
      err_bad_type_d = (err_bad_type_q && !err_clr) || w_is_bad;

      txn_count_d = txn_count_q;
      if (w_commit) begin
         txn_count_d = txn_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         txn_count_q    <= '0;
         err_overflow_q <= 1'b0;
         err_too_long_q <= 1'b0;
         err_bad_type_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         txn_count_q    <= txn_count_d;
         err_overflow_q <= err_overflow_d;
         err_too_long_q <= err_too_long_d;
         err_bad_type_q <= err_bad_type_d;
      end
   end

   assign txn_count    = txn_count_q;
   assign err_overflow = err_overflow_q;
   assign err_too_long = err_too_long_q;
   assign err_bad_type = err_bad_type_q;

endmodule
`default_nettype wire

// File: tb/tb_hero_write_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_hero_write_rx                                         |
// | Purpose   : Self-checking bench for hero_write_rx. A queue-based     |
// |             reference model tracks committed and pending beats.      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_hero_write_rx;
   import test_pkg_a::*;
   import hero_rx_pkg::*;

   localparam int DEPTH = 16;
   localparam int MAXB  = 8;

   logic        clk = 1'b0;
   logic        rst;
   hero_write   hero_in;
   logic        out_valid, out_ready, out_last;
   logic [35:0] out_data;
   logic [15:0] txn_count;
   logic        err_overflow, err_too_long, err_bad_type, err_clr;

   always #5 clk = ~clk;

   hero_write_rx #(
      .DEPTH     (DEPTH),
      .MAX_BEATS (MAXB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hero_in      (hero_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .txn_count    (txn_count),
      .err_overflow (err_overflow),
      .err_too_long (err_too_long),
      .err_bad_type (err_bad_type),
      .err_clr      (err_clr)
   );

   int total = 0;
   int passed = 0;
   int fails = 0;

   // Reference model: visible beats, the open transaction, drop mode.
   logic [36:0] mq[$];
   logic [36:0] pq[$];
   bit          dropping;
   logic [15:0] m_txn;
   bit          m_ovf, m_long, m_bad;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 36'(out_valid), 36'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk({tag, ".data"}, out_data, mq[0][35:0]);
         chk({tag, ".last"}, 36'(out_last), 36'(mq[0][36]));
      end
      chk({tag, ".txn_count"}, 36'(txn_count), 36'(m_txn));
      chk({tag, ".err_overflow"}, 36'(err_overflow), 36'(m_ovf));
      chk({tag, ".err_too_long"}, 36'(err_too_long), 36'(m_long));
      chk({tag, ".err_bad_type"}, 36'(err_bad_type), 36'(m_bad));
   endtask

   task automatic model_clear();
      mq.delete();
      pq.delete();
      dropping = 1'b0;
      m_txn = '0;
      m_ovf = 1'b0;
      m_long = 1'b0;
      m_bad = 1'b0;
   endtask

   task automatic model_update(input logic [3:0] ct, input logic [35:0] d,
                               input bit en, input bit rdy, input bit clr);
      int occ;
      bit so, sl, sb, is_beat, is_done;
      occ     = mq.size() + pq.size();
      so      = 1'b0;
      sl      = 1'b0;
      is_done = (ct == 4'h2);
      is_beat = en && (ct == 4'h1 || is_done);
      sb      = en && !(ct == 4'h0 || ct == 4'h1 || is_done);
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (is_beat) begin
         if (dropping) begin
            if (is_done) dropping = 1'b0;
         end else if (occ == DEPTH) begin
            so = 1'b1;
            pq.delete();
            dropping = !is_done;
         end else if (pq.size() == MAXB) begin
            sl = 1'b1;
            pq.delete();
            dropping = !is_done;
         end else begin
            pq.push_back({is_done, d});
            if (is_done) begin
               foreach (pq[i]) mq.push_back(pq[i]);
               pq.delete();
               m_txn = m_txn + 16'd1;
            end
         end
      end
      m_ovf  = (m_ovf && !clr) || so;
      m_long = (m_long && !clr) || sl;
      m_bad  = (m_bad && !clr) || sb;
   endtask

   task automatic step(input string tag, input logic [3:0] ct, input logic [35:0] d,
                       input bit en, input bit rdy, input bit clr);
      @(negedge clk);
      hero_in   = '{cycle_type: CYCLE_TYPE'(ct), wdat: d, clk_en: en};
      out_ready = rdy;
      err_clr   = clr;
      #1;
      check_outputs(tag);
      model_update(ct, d, en, rdy, clr);
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      hero_in   = '{cycle_type: IDLE, wdat: 36'h0, clk_en: 1'b0};
      out_ready = 1'b0;
      err_clr   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_outputs("reset");
   endtask

   task automatic drain(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 4'h0, 36'h0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int r;
      bit en, rdy, clr, heavy;
      logic [3:0] ct;

      rst = 1'b1;
      model_clear();
      do_reset();

      // Three-beat transaction, released one cycle after DONE.
      step("r34", 4'h1, 36'h1, 1'b1, 1'b1, 1'b0);
      step("r34", 4'h1, 36'h2, 1'b1, 1'b1, 1'b0);
      step("r34", 4'h2, 36'h3, 1'b1, 1'b1, 1'b0);
      drain("r34", 4);

      // Lone DONE in idle is a single-beat transaction.
      step("r35", 4'h2, 36'hA, 1'b1, 1'b1, 1'b0);
      drain("r35", 2);

      // Fill with two 8-beat transactions, then overflow a third.
      do_reset();
      for (int t = 0; t < 3; t++) begin
         for (int b = 0; b < 7; b++) step("r36", 4'h1, 36'(t * 16 + b), 1'b1, 1'b0, 1'b0);
         step("r36", 4'h2, 36'(t * 16 + 7), 1'b1, 1'b0, 1'b0);
      end
      step("r36", 4'h0, 36'h0, 1'b0, 1'b0, 1'b0);
      chk("r36.overflow_flag", 36'(err_overflow), 36'h1);
      drain("r36", 18);

      // Nine VALIDs exceed MAX_BEATS; next short transaction still works.
      do_reset();
      for (int b = 0; b < 9; b++) step("r37", 4'h1, 36'(b + 100), 1'b1, 1'b1, 1'b0);
      step("r37", 4'h2, 36'd200, 1'b1, 1'b1, 1'b0);
      step("r37", 4'h0, 36'h0, 1'b0, 1'b1, 1'b0);
      chk("r37.too_long_flag", 36'(err_too_long), 36'h1);
      chk("r37.no_commit", 36'(txn_count), 36'h0);
      step("r37", 4'h1, 36'h77, 1'b1, 1'b1, 1'b0);
      step("r37", 4'h2, 36'h78, 1'b1, 1'b1, 1'b0);
      drain("r37", 4);

      // Illegal cycle type flags only when qualified and leaves state alone.
      do_reset();
      step("r38", 4'h1, 36'h11, 1'b1, 1'b1, 1'b0);
      step("r38", 4'h7, 36'h99, 1'b1, 1'b1, 1'b0);
      step("r38", 4'h2, 36'h22, 1'b1, 1'b1, 1'b0);
      chk("r38.bad_flag", 36'(err_bad_type), 36'h1);
      step("r38", 4'h0, 36'h0, 1'b0, 1'b1, 1'b1);
      step("r38", 4'h7, 36'h99, 1'b0, 1'b1, 1'b0);
      step("r38", 4'h0, 36'h0, 1'b0, 1'b1, 1'b0);
      chk("r38.no_flag_unqualified", 36'(err_bad_type), 36'h0);
      // Clear coinciding with a new error: the error stays set.
      step("r27", 4'h7, 36'h0, 1'b1, 1'b1, 1'b1);
      drain("r27", 2);

      // Reset mid-transaction discards the partial beats.
      do_reset();
      for (int b = 0; b < 3; b++) step("r39", 4'h1, 36'(b + 1), 1'b1, 1'b1, 1'b0);
      do_reset();
      step("r39", 4'h2, 36'h5, 1'b1, 1'b1, 1'b0);
      step("r39", 4'h0, 36'h0, 1'b0, 1'b1, 1'b0);
      chk("r39.txn_count", 36'(txn_count), 36'h1);
      drain("r39", 2);

      // Randomized traffic: a flowing phase then a congested phase.
      for (int i = 0; i < 1200; i++) begin
         heavy = (i >= 600);
         r     = $urandom_range(0, 15);
         if (heavy) ct = (r < 1) ? 4'h0 : (r < 12) ? 4'h1 : (r < 14) ? 4'h2 : 4'h9;
         else       ct = (r < 2) ? 4'h0 : (r < 9)  ? 4'h1 : (r < 14) ? 4'h2 :
                         (r == 14) ? 4'h7 : 4'hC;
         en  = ($urandom_range(0, 7) != 0);
         rdy = heavy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 31) == 0);
         step("rand", ct, {$urandom, 4'($urandom)}, en, rdy, clr);
      end
      drain("final", 24);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
